// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for rst_sequencer: FSM state encodings, default parameter values
// and the active-high reset-output levels reused from the core.
package rst_sequencer_pkg;

   localparam logic [1:0] S_HOLD    = 2'd0;
   localparam logic [1:0] S_RELEASE = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;
   localparam logic [1:0] S_FINISH  = 2'd3;

   localparam int DEF_CH_NUM         = 2;
   localparam int DEF_HOLD_CYCLES    = 10;
   localparam int DEF_STAGE_GAP      = 4;
   localparam int DEF_TIMEOUT_CYCLES = 500;
   localparam int DEF_CNT_W          = 16;

   localparam logic RstEnable  = 1'b1;
   localparam logic RstDisable = 1'b0;

   // Edge (counted from the first edge with rst high) on which channel k leaves reset.
   function automatic int release_edge(input int hold, input int gap, input int k);
      return hold + k * gap;
   endfunction

endpackage

// File: rtl/rst_sequencer_sat_counter.sv
// sat_counter: W-bit up-counter with synchronous clear, enable, saturation at all-ones
// and an equality flag against a compare value.
module sat_counter
   import rst_sequencer_pkg::*;
#(
   parameter int W = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] cmp,
   output logic [W-1:0] cnt,
   output logic         eq
);

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign eq = (cnt == cmp);

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: staged reset release, run-phase cycle counting and end-of-run flags.
// Define WDG_TIMEOUT_EN to build the run-phase watchdog; otherwise timeout_o stays 0.
module rst_sequencer
   import rst_sequencer_pkg::*;
#(
   parameter int CH_NUM         = DEF_CH_NUM,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int STAGE_GAP      = DEF_STAGE_GAP,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_rst_i,
   input  logic              done_i,
   output logic [CH_NUM-1:0] ch_rst_o,
   output logic              run_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic [CNT_W-1:0]  cycle_cnt_o
);

   localparam logic [CH_NUM-1:0] CH_ALL_RST = {CH_NUM{RstEnable}};
   localparam logic [CH_NUM-1:0] CH_ALL_REL = {CH_NUM{RstDisable}};

   logic [1:0]        state_reg, state_next;
   logic [CH_NUM-1:0] ch_rst_reg, ch_rst_next;
   logic              run_reg, run_next;
   logic              done_reg, done_next;
   logic              timeout_reg, timeout_next;

   logic              cnt_clr, seq_en, cyc_en;
   logic [CNT_W-1:0]  seq_cnt;
   logic              seq_eq;
   logic              wdg_hit;
   logic [CH_NUM-1:0] rel_hit;
`ifndef WDG_TIMEOUT_EN
   logic              wdg_unused;
   assign wdg_hit = 1'b0;
`endif

   assign cnt_clr = !rst || soft_rst_i;
   assign seq_en  = (state_reg == S_HOLD) || (state_reg == S_RELEASE);
   assign cyc_en  = (state_reg == S_RUN);

   sat_counter #(.W(CNT_W)) u_seq_cnt (
      .clk (clk),
      .clr (cnt_clr),
      .en  (seq_en),
      .cmp (CNT_W'(HOLD_CYCLES - 1)),
      .cnt (seq_cnt),
      .eq  (seq_eq)
   );

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk (clk),
      .clr (cnt_clr),
      .en  (cyc_en),
      .cmp (CNT_W'(TIMEOUT_CYCLES - 1)),
      .cnt (cycle_cnt_o),
`ifdef WDG_TIMEOUT_EN
      .eq  (wdg_hit)
`else
      .eq  (wdg_unused)
`endif
   );

   // seq_cnt holds the edge count minus one, so matching edge-1 releases on that edge.
   for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_rel
      localparam logic [CNT_W-1:0] REL_AT =
         CNT_W'(release_edge(HOLD_CYCLES, STAGE_GAP, gi) - 1);
      assign rel_hit[gi] = seq_en && (seq_cnt == REL_AT);
   end

   always_comb begin
      state_next   = state_reg;
      ch_rst_next  = ch_rst_reg;
      run_next     = run_reg;
      done_next    = done_reg;
      timeout_next = timeout_reg;
      if (soft_rst_i) begin
         state_next   = S_HOLD;
         ch_rst_next  = CH_ALL_RST;
         run_next     = 1'b0;
         done_next    = 1'b0;
         timeout_next = 1'b0;
      end else begin
         case (state_reg)
            S_HOLD: begin
               ch_rst_next = ch_rst_reg & ~rel_hit;
               if (seq_eq) state_next = S_RELEASE;
            end
            S_RELEASE: begin
               ch_rst_next = ch_rst_reg & ~rel_hit;
               if (ch_rst_reg == CH_ALL_REL) begin
                  state_next = S_RUN;
                  run_next   = 1'b1;
               end
            end
            S_RUN: begin
               // done_i takes precedence over a coincident watchdog expiry
               if (done_i) begin
                  state_next  = S_FINISH;
                  ch_rst_next = CH_ALL_RST;
                  run_next    = 1'b0;
                  done_next   = 1'b1;
               end else if (wdg_hit) begin
                  state_next   = S_FINISH;
                  ch_rst_next  = CH_ALL_RST;
                  run_next     = 1'b0;
                  timeout_next = 1'b1;
               end
            end
            S_FINISH: begin
            end
            default: state_next = S_HOLD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= S_HOLD;
         ch_rst_reg  <= CH_ALL_RST;
         run_reg     <= 1'b0;
         done_reg    <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ch_rst_reg  <= ch_rst_next;
         run_reg     <= run_next;
         done_reg    <= done_next;
         timeout_reg <= timeout_next;
      end
   end

   assign ch_rst_o  = ch_rst_reg;
   assign run_o     = run_reg;
   assign done_o    = done_reg;
   assign timeout_o = timeout_reg;

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset/run sequencer for the SOPC: holds the core and peripherals in reset, releases up to CH_NUM reset domains in staggered order, then tracks the run phase with a saturating cycle counter and an optional watchdog. It replaces fixed-delay reset/timeout generation with a synthesizable, cycle-exact block that can front `mips_sopc` in simulation and on board. End of run is flagged through `done_o` (completion) or `timeout_o` (watchdog).

## Interface
- CH_NUM, 2, number of staged reset channels (>=1)
- HOLD_CYCLES, 10, cycles all channels stay in reset after `rst` deasserts (>=1)
- STAGE_GAP, 4, cycles between successive channel releases (>=1)
- TIMEOUT_CYCLES, 500, run-phase cycles before watchdog fires (1 .. 2^CNT_W-1)
- CNT_W, 16, width of the sequencing and cycle counters; HOLD_CYCLES+(CH_NUM-1)*STAGE_GAP must fit
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- soft_rst_i  in  1  restart request; re-enters reset hold
- done_i  in  1  end-of-run indication from the design under control
- ch_rst_o  out  CH_NUM  per-channel reset, active-high; bit k is released k-th
- run_o  out  1  high while in RUN
- done_o  out  1  sticky: run ended via done_i
- timeout_o  out  1  sticky: run ended via watchdog
- cycle_cnt_o  out  CNT_W  run-phase cycle count, saturating

## Operation
- States: S_HOLD, S_RELEASE, S_RUN, S_FINISH.
- `rst`=0 sampled: S_HOLD; ch_rst_o all 1; run_o, done_o, timeout_o 0; cycle_cnt_o 0; internal seq_cnt 0.
- S_HOLD/S_RELEASE: seq_cnt increments every edge. ch_rst_o[k] goes 0 on the (HOLD_CYCLES + k*STAGE_GAP)-th rising edge after `rst` is first sampled 1. S_HOLD -> S_RELEASE when ch 0 releases. Released channels stay released.
- After the last channel releases: S_RUN on the next edge, run_o=1.
- S_RUN: cycle_cnt_o increments each edge and saturates at all-ones.
- S_RUN, done_i=1: next edge S_FINISH, done_o=1.
- S_RUN, watchdog enabled, cycle_cnt_o == TIMEOUT_CYCLES-1: next edge S_FINISH, timeout_o=1.
- done_i and watchdog expiry on the same edge: done wins (done_o=1, timeout_o=0).
- S_FINISH: ch_rst_o all 1, run_o 0, cycle_cnt_o frozen. done_o/timeout_o stay set until `rst` or soft_rst_i.
- soft_rst_i=1 in any state: next edge S_HOLD with full reset values, including clearing done_o/timeout_o and cycle_cnt_o. While held high, seq_cnt stays 0. Staging restarts on the first edge after soft_rst_i falls.
- done_i is ignored outside S_RUN. `rst` has priority over soft_rst_i.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Defaults, `rst` first sampled 1 at edge 1:
  - ch_rst_o[0] falls at edge 10.
  - ch_rst_o[1] falls at edge 14.
  - run_o rises at edge 15; cycle_cnt_o is 0 in the first RUN cycle.
  - Without done_i, timeout_o rises at edge 15+500.
- done_i to done_o: 1 cycle. done_o to ch_rst_o reasserted: same edge.
- `rst` asserted mid-run: all outputs take reset values on that edge.

## Configuration
- WDG_TIMEOUT_EN defined: watchdog compare is present and timeout_o behaves as above.
- WDG_TIMEOUT_EN undefined:
  - timeout_o is constant 0 and TIMEOUT_CYCLES is unused.
  - S_RUN exits only on done_i, soft_rst_i or `rst`.
  - cycle_cnt_o still counts and saturates.

## Structure
- Shared defines header holds:
  - the state encodings S_HOLD..S_FINISH (2 bits);
  - the default parameter values;
  - the active-high reset-output level, which reuses the core's existing RstEnable/RstDisable levels.
- One sub-module, `sat_counter`: CNT_W-bit counter with clear, enable and saturation, plus an equality-compare output. It is instantiated for seq_cnt and for the run/watchdog counter.
- Top level contains only the FSM and output registers.

## Test plan
- Default params, `rst` low 5 cycles then high -> ch_rst_o: 2'b11 through edge 9, 2'b10 at edge 10, 2'b00 at edge 14; run_o 1 at edge 15.
- CH_NUM=4, HOLD_CYCLES=3, STAGE_GAP=1 -> channel releases at edges 3, 4, 5, 6; run_o at edge 7.
- done_i pulse at RUN cycle 20 -> done_o=1 and ch_rst_o all 1 next edge; cycle_cnt_o frozen at 21; timeout_o never set.
- WDG_TIMEOUT_EN, TIMEOUT_CYCLES=8, no done_i:
  - timeout_o=1 eight edges after run_o rises.
  - Repeat with done_i asserted on that same edge -> done_o=1, timeout_o=0.
- soft_rst_i for 2 cycles during S_FINISH -> all flags cleared, ch_rst_o all 1; release sequence repeats with identical edge offsets from the soft_rst_i fall.
- `rst` low mid-RELEASE (after ch 0 released) -> ch_rst_o all 1 next edge; restaging from edge 1 on deassertion. CNT_W=4 without WDG_TIMEOUT_EN -> cycle_cnt_o saturates at 15.
